// File: rtl/edge_event_detector.sv
// Multi-channel edge event detector: per channel a synchroniser, a persistence
// glitch filter, mode-selected edge pulse, sticky pending/overflow and a saturating count.
module edge_event_detector #(
    parameter int p_WIDTH         = 4,
    parameter int p_SYNC_STAGES   = 2,
    parameter int p_FILTER_CYCLES = 4,
    parameter int p_CNT_WIDTH     = 8,
    parameter int p_IDLE_LEVEL    = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [p_WIDTH-1:0]             iv_input,
    input  logic [2*p_WIDTH-1:0]           iv_mode,
    input  logic [p_WIDTH-1:0]             iv_clear,
    output logic [p_WIDTH-1:0]             ov_level,
    output logic [p_WIDTH-1:0]             ov_pulse,
    output logic [p_WIDTH-1:0]             ov_pending,
    output logic [p_WIDTH-1:0]             ov_overflow,
    output logic [p_WIDTH*p_CNT_WIDTH-1:0] ov_count
);

    localparam int FCW = (p_FILTER_CYCLES > 1) ? $clog2(p_FILTER_CYCLES) : 1;
    localparam logic [FCW-1:0]         FC_LAST   = FCW'(p_FILTER_CYCLES - 1);
    localparam logic [FCW-1:0]         FCNT_ONE  = FCW'(1);
    localparam logic [p_CNT_WIDTH-1:0] CNT_ONE   = p_CNT_WIDTH'(1);
    localparam logic [p_CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic                   IDLE_BIT  = (p_IDLE_LEVEL != 0);

    genvar gi;
    generate
        for (gi = 0; gi < p_WIDTH; gi++) begin : g_chan
            logic [p_SYNC_STAGES-1:0] sync_reg;
            logic                     level_reg;
            logic [FCW-1:0]           fcnt_reg;
            logic                     pulse_reg;
            logic                     pending_reg;
            logic                     overflow_reg;
            logic [p_CNT_WIDTH-1:0]   count_reg;

            logic sync_k;
            logic transition;
            logic event_k;

            assign sync_k     = sync_reg[p_SYNC_STAGES-1];
            assign transition = (sync_k != level_reg) && (fcnt_reg == FC_LAST);
            // sync_k is the new level on a transition: 1 means rising, 0 falling
            assign event_k    = transition && (sync_k ? iv_mode[2*gi] : iv_mode[2*gi+1]);

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    sync_reg     <= {p_SYNC_STAGES{IDLE_BIT}};
                    level_reg    <= IDLE_BIT;
                    fcnt_reg     <= '0;
                    pulse_reg    <= 1'b0;
                    pending_reg  <= 1'b0;
                    overflow_reg <= 1'b0;
                    count_reg    <= '0;
                end else begin
                    sync_reg  <= {sync_reg[p_SYNC_STAGES-2:0], iv_input[gi]};
                    pulse_reg <= event_k;

                    if (sync_k == level_reg) begin
                        fcnt_reg <= '0;
                    end else if (transition) begin
                        level_reg <= sync_k;
                        fcnt_reg  <= '0;
                    end else begin
                        fcnt_reg <= fcnt_reg + FCNT_ONE;
                    end

                    // A coincident clear wipes history first, so the event restarts the count
                    if (event_k) begin
                        pending_reg <= 1'b1;
                        if (iv_clear[gi]) begin
                            count_reg    <= CNT_ONE;
                            overflow_reg <= 1'b0;
                        end else begin
                            overflow_reg <= overflow_reg | pending_reg;
                            if (count_reg != CNT_MAX) begin
                                count_reg <= count_reg + CNT_ONE;
                            end
                        end
                    end else if (iv_clear[gi]) begin
                        pending_reg  <= 1'b0;
                        overflow_reg <= 1'b0;
                        count_reg    <= '0;
                    end
                end
            end

            assign ov_level[gi]    = level_reg;
            assign ov_pulse[gi]    = pulse_reg;
            assign ov_pending[gi]  = pending_reg;
            assign ov_overflow[gi] = overflow_reg;
            assign ov_count[gi*p_CNT_WIDTH +: p_CNT_WIDTH] = count_reg;
        end
    endgenerate

endmodule

// File: doc/edge_event_detector.md
Name: edge_event_detector

Overview:
Multi-channel successor to the single-mode edge detector. Each channel passes through a synchroniser and a glitch filter, then detects edges in a runtime-selectable mode (rise, fall or both). Each channel produces a one-cycle pulse, a sticky pending flag with clear, a saturating event counter and an overflow flag. It sits between asynchronous board inputs (buttons, external strobes) and the control logic.

Parameters:
p_WIDTH, 4, number of independent channels (>=1)
p_SYNC_STAGES, 2, synchroniser flops per channel (>=2)
p_FILTER_CYCLES, 4, consecutive cycles a new level must persist before it is accepted (>=1)
p_CNT_WIDTH, 8, per-channel event counter width (>=1)
p_IDLE_LEVEL, 0, reset level (0/1) loaded into every sync and filtered-level flop

Ports:
i_clk  in  1  clock; all logic on posedge
i_rst  in  1  synchronous reset, active-high
iv_input  in  p_WIDTH  asynchronous raw inputs
iv_mode  in  2*p_WIDTH  per-channel mode, bits [2k+1:2k]: 00 off, 01 rise, 10 fall, 11 both
iv_clear  in  p_WIDTH  per-channel clear of pending, overflow and count
ov_level  out  p_WIDTH  filtered, synchronised level
ov_pulse  out  p_WIDTH  one-cycle edge pulse per channel
ov_pending  out  p_WIDTH  sticky event flag
ov_overflow  out  p_WIDTH  sticky: an event arrived while pending was already set
ov_count  out  p_WIDTH*p_CNT_WIDTH  per-channel saturating event count, channel k at [k*p_CNT_WIDTH +: p_CNT_WIDTH]

Behaviour:
- Reset (i_rst=1 at posedge) loads:
  - sync chain and ov_level to p_IDLE_LEVEL;
  - filter counters to 0;
  - ov_pulse, ov_pending, ov_overflow and ov_count to 0.
  - Reset overrides all other inputs. Reset mid-filter discards the partial count.
- Synchroniser: p_SYNC_STAGES-flop chain per channel. Its last stage, sync_k, feeds the filter.
- Filter, per channel, at each edge:
  - sync_k == level: filter counter <= 0.
  - sync_k != level and counter == p_FILTER_CYCLES-1: level <= sync_k, counter <= 0. This is a level transition.
  - sync_k != level otherwise: counter increments.
  - A glitch shorter than p_FILTER_CYCLES synchronised cycles produces no level change.
- Latency: the input changes before edge 1 and is held. ov_level and ov_pulse change at edge p_SYNC_STAGES + p_FILTER_CYCLES (edge 6 with the defaults).
- Edge qualification: on a level transition 0->1, ov_pulse_k = mode[0]. On a transition 1->0, ov_pulse_k = mode[1]. ov_pulse is registered and high exactly one cycle per qualified transition. Transitions are at least p_FILTER_CYCLES apart, so pulses never merge.
- Mode off (00): ov_level still tracks. No pulse, no pending/count/overflow update.
- Mode changes apply to the transition evaluated at the same edge the new mode is sampled. Mode changes never disturb the filter state.
- Pending, count and overflow update at the edge where the pulse is registered (pulse event e_k):
  - e_k & ~clear_k: pending <= 1; count <= count+1, saturating at all ones; overflow <= overflow | pending (old value).
  - clear_k & ~e_k: pending <= 0, count <= 0, overflow <= 0.
  - clear_k & e_k (simultaneous): clear applies first, then the event. Result: pending=1, count=1, overflow=0. Events are never lost.
- Count saturation: the counter holds at 2^p_CNT_WIDTH-1. Overflow still follows the pending rule independently of saturation.
- Channels are fully independent; no cross-channel interaction.
- No spurious pulse after reset when the input is already at p_IDLE_LEVEL. An input at the opposite level after reset is treated as a real edge after the full latency.

Test Plan:
- Defaults, reset, input ch0 0->1 held, mode ch0=01 -> ov_level[0] and ov_pulse[0] rise at edge 6; pulse lasts 1 cycle; pending[0]=1; count ch0=1.
- Glitch: ch1 mode=11, input high for 3 cycles then low -> no level change, no pulse, count=0. Input high for 4 cycles -> one rise pulse; later 4-cycle low -> one fall pulse; count=2.
- Mode fall-only (10) ch2, full 0->1->0 cycle -> exactly one pulse, on the falling transition. Mode 00 -> level toggles, pulse/pending/count stay 0.
- Overflow and clear: two qualified events on ch3 without clear -> pending=1, overflow=1, count=2. iv_clear[3] for 1 cycle -> all 0. Clear coincident with a pulse -> pending=1, count=1, overflow=0.
- Saturation with p_CNT_WIDTH=2: 5 events -> count stays 3 after the 3rd event.
- i_rst asserted with ch0 at filter count 2 -> next cycle all outputs 0 and level=p_IDLE_LEVEL. The held input produces a pulse a full 6 edges after reset release.
